cs_sched: RTL and testbench

CS_SCHED -- requirements
Module: cs_sched

---
 rtl/cs_sched.sv | 210 +++++++++++++++++++++
 tb/tb_cs_sched.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cs_sched.sv
// cs_sched: four-channel scheduler in front of a shared windowed-average engine.
// Arbitrates sample requests, services window flushes, tracks per-channel
// warm-up and forwards engine results once a channel's window is full.
// Build option: define CS_SCHED_PRIO_EN to give channel 0 fixed priority,
// with channels 1-3 round-robin among themselves.
module cs_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] x_bus,
  input  logic [3:0]  flush,
  output logic [3:0]  gnt,
  output logic [3:0]  flush_ack,
  output logic [7:0]  eng_x,
  output logic [1:0]  eng_ch,
  output logic        eng_load,
  output logic        eng_clr,
  input  logic [9:0]  eng_y,
  input  logic        eng_done,
  output logic [9:0]  y_out,
  output logic [1:0]  y_ch,
  output logic        y_valid,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [3:0] CNT_SAT = 4'd9;

  logic [1:0] state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [1:0] win_q, win_d;
  logic [3:0] cnt_q [4];
  logic [3:0] cnt_d [4];

  logic [3:0] gnt_q, gnt_d;
  logic [3:0] flush_ack_q, flush_ack_d;
  logic [7:0] eng_x_q, eng_x_d;
  logic [1:0] eng_ch_q, eng_ch_d;
  logic       eng_load_q, eng_load_d;
  logic       eng_clr_q, eng_clr_d;
  logic [9:0] y_out_q, y_out_d;
  logic [1:0] y_ch_q, y_ch_d;
  logic       y_valid_q, y_valid_d;
  logic       busy_q, busy_d;

  logic [3:0] fl_pend;
  logic       fl_hit;
  logic [1:0] fl_pick;
  logic       arb_hit;
  logic [1:0] arb_pick;

  // Lowest-indexed pending flush. The channel being acked this cycle still
  // holds its flush level, so it is masked to avoid servicing it twice.
  always_comb begin
    fl_pend = flush & ~flush_ack_q;
    fl_hit  = 1'b0;
    fl_pick = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (fl_pend[k] && !fl_hit) begin
        fl_hit  = 1'b1;
        fl_pick = 2'(k);
      end
    end
  end

  // Request arbitration: round-robin starting after the last granted channel.
  always_comb begin
    arb_hit  = 1'b0;
    arb_pick = '0;
`ifdef CS_SCHED_PRIO_EN
    begin
      logic [2:0] c;
      c = '0;
      if (req[0]) begin
        arb_hit = 1'b1;
      end else begin
        for (int unsigned k = 1; k <= 3; k++) begin
          c = {1'b0, last_q} + 3'(k);
          if (c > 3'd3) c = c - 3'd3;
          if (!arb_hit && req[c[1:0]]) begin
            arb_hit  = 1'b1;
            arb_pick = c[1:0];
          end
        end
      end
    end
`else
    begin
      logic [1:0] c;
      c = '0;
      for (int unsigned k = 1; k <= 4; k++) begin
        c = last_q + 2'(k);
        if (!arb_hit && req[c]) begin
          arb_hit  = 1'b1;
          arb_pick = c;
        end
      end
    end
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    flush_ack_d = '0;
    eng_load_d  = 1'b0;
    eng_clr_d   = 1'b0;
    y_valid_d   = 1'b0;
    eng_x_d     = eng_x_q;
    eng_ch_d    = eng_ch_q;
    y_out_d     = y_out_q;
    y_ch_d      = y_ch_q;
    case (state_q)
      IDLE: begin
        if (fl_hit) begin
          flush_ack_d[fl_pick] = 1'b1;
          eng_clr_d            = 1'b1;
          eng_ch_d             = fl_pick;
          cnt_d[fl_pick]       = '0;
        end else if (arb_hit) begin
          win_d           = arb_pick;
          gnt_d[arb_pick] = 1'b1;
          eng_load_d      = 1'b1;
          eng_ch_d        = arb_pick;
          eng_x_d         = x_bus[{arb_pick, 3'b000} +: 8];
          state_d         = ISSUE;
`ifdef CS_SCHED_PRIO_EN
          if (arb_pick != 2'd0) last_d = arb_pick;
`else
          last_d = arb_pick;
`endif
        end
      end
      ISSUE: begin
        if (cnt_q[win_q] != CNT_SAT) cnt_d[win_q] = cnt_q[win_q] + 4'd1;
        state_d = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          y_out_d   = eng_y;
          y_ch_d    = win_q;
          y_valid_d = (cnt_q[win_q] == CNT_SAT);
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 2'd3;
      win_q       <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
      gnt_q       <= '0;
      flush_ack_q <= '0;
      eng_x_q     <= '0;
      eng_ch_q    <= '0;
      eng_load_q  <= 1'b0;
      eng_clr_q   <= 1'b0;
      y_out_q     <= '0;
      y_ch_q      <= '0;
      y_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      gnt_q       <= gnt_d;
      flush_ack_q <= flush_ack_d;
      eng_x_q     <= eng_x_d;
      eng_ch_q    <= eng_ch_d;
      eng_load_q  <= eng_load_d;
      eng_clr_q   <= eng_clr_d;
      y_out_q     <= y_out_d;
      y_ch_q      <= y_ch_d;
      y_valid_q   <= y_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign flush_ack = flush_ack_q;
  assign eng_x     = eng_x_q;
  assign eng_ch    = eng_ch_q;
  assign eng_load  = eng_load_q;
  assign eng_clr   = eng_clr_q;
  assign y_out     = y_out_q;
  assign y_ch      = y_ch_q;
  assign y_valid   = y_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cs_sched.sv
// tb_cs_sched: directed scenarios plus randomized traffic for cs_sched,
// checked every cycle against a transaction-level reference model.
module tb_cs_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, flush;
  logic [31:0] x_bus;
  logic [9:0]  eng_y;
  logic        eng_done;
  logic [3:0]  gnt, flush_ack;
  logic [7:0]  eng_x;
  logic [1:0]  eng_ch, y_ch;
  logic        eng_load, eng_clr, y_valid, busy;
  logic [9:0]  y_out;

  always #5 clk = ~clk;

  cs_sched dut (
    .clk(clk), .reset(reset), .req(req), .x_bus(x_bus), .flush(flush),
    .gnt(gnt), .flush_ack(flush_ack), .eng_x(eng_x), .eng_ch(eng_ch),
    .eng_load(eng_load), .eng_clr(eng_clr), .eng_y(eng_y), .eng_done(eng_done),
    .y_out(y_out), .y_ch(y_ch), .y_valid(y_valid), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 issue, 2 wait, 3 done.
  int         m_phase, m_win, m_last;
  int         m_cnt [4];
  logic [3:0] m_ack_prev;
  // Inputs as the DUT will sample them at the next edge.
  logic [3:0]  s_req, s_flush;
  logic [31:0] s_x;
  logic        s_done;
  logic [9:0]  s_y;
  // Engine and requester behaviour.
  int         eng_wait = 0;
  int         eng_delay = 1;
  bit         eng_fixed = 1'b1;
  logic [9:0] eng_val;
  bit         hold_mode = 1'b0;
  bit         rand_mode = 1'b0;
  logic [3:0] gnt_log [$];
  int         load_cnt;

  function automatic int exp_pick(input logic [3:0] r);
    int c;
`ifdef CS_SCHED_PRIO_EN
    if (r[0]) return 0;
    for (int k = 1; k <= 3; k++) begin
      c = ((m_last + k - 1) % 3) + 1;
      if (r[c]) return c;
    end
`else
    for (int k = 1; k <= 4; k++) begin
      c = (m_last + k) % 4;
      if (r[c]) return c;
    end
`endif
    return 0;
  endfunction

  task automatic snap();
    s_req = req; s_flush = flush; s_x = x_bus; s_done = eng_done; s_y = eng_y;
  endtask

  task automatic model_reset();
    m_phase = 0; m_win = 0; m_last = 3; m_ack_prev = '0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic step();
    logic [3:0] e_gnt, e_ack, fl;
    logic       e_load, e_clr, e_yv;
    logic [7:0] e_x;
    logic [9:0] e_y;
    int         nxt, w, f;
    @(posedge clk);
    #1;
    e_gnt = '0; e_ack = '0; e_load = 1'b0; e_clr = 1'b0; e_yv = 1'b0;
    e_x = '0; e_y = '0; w = 0; f = 0; nxt = m_phase;
    case (m_phase)
      0: begin
        fl = s_flush & ~m_ack_prev;
        if (fl != 0) begin
          for (int i = 3; i >= 0; i--) if (fl[i]) f = i;
          e_ack[f] = 1'b1; e_clr = 1'b1; m_cnt[f] = 0;
        end else if (s_req != 0) begin
          w = exp_pick(s_req);
`ifdef CS_SCHED_PRIO_EN
          if (w != 0) m_last = w;
`else
          m_last = w;
`endif
          m_win = w;
          m_cnt[w] = (m_cnt[w] >= 9) ? 9 : m_cnt[w] + 1;
          e_gnt[w] = 1'b1; e_load = 1'b1; e_x = s_x[8*w +: 8];
          nxt = 1;
        end
      end
      1: nxt = 2;
      2: if (s_done) begin
        e_yv = (m_cnt[m_win] == 9); e_y = s_y; nxt = 3;
      end
      default: nxt = 0;
    endcase
    m_phase = nxt;
    m_ack_prev = e_ack;
    chk("ctl{gnt,ack,load,clr,yv,busy}", 64'({gnt, flush_ack, eng_load, eng_clr, y_valid, busy}),
        64'({e_gnt, e_ack, e_load, e_clr, e_yv, (nxt != 0)}));
    if (e_load) begin
      chk("eng_x", 64'(eng_x), 64'(e_x));
      chk("eng_ch_load", 64'(eng_ch), 64'(w));
    end
    if (e_clr) chk("eng_ch_clr", 64'(eng_ch), 64'(f));
    if (nxt == 3) begin
      chk("y_out", 64'(y_out), 64'(e_y));
      chk("y_ch", 64'(y_ch), 64'(m_win));
    end
    if (gnt != 0) gnt_log.push_back(gnt);
    if (eng_load) load_cnt++;
    // engine: result after a programmable number of cycles
    eng_done = 1'b0;
    if (eng_wait > 0) begin
      eng_wait--;
      if (eng_wait == 0) begin eng_done = 1'b1; eng_y = eng_val; end
    end else begin
      eng_y = 10'($urandom);
    end
    if (eng_load) begin
      eng_wait = (eng_delay > 0) ? eng_delay : int'($urandom_range(1, 3));
      eng_val  = eng_fixed ? 10'h0F0 : 10'($urandom);
    end
    // requesters
    for (int i = 0; i < 4; i++) begin
      if (gnt[i] && !hold_mode) req[i] = 1'b0;
      if (flush_ack[i]) flush[i] = 1'b0;
      if (rand_mode && !gnt[i]) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1; x_bus[8*i +: 8] = 8'($urandom);
        end else if (req[i] && $urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
        if (!flush[i] && !flush_ack[i] && $urandom_range(0, 31) == 0) flush[i] = 1'b1;
      end
    end
    snap();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_outputs", 64'({gnt, flush_ack, eng_x, eng_ch, eng_load, eng_clr, y_out, y_ch, y_valid, busy}), '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    snap();
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      if (m_phase == 0 && req == 0 && flush == 0) break;
      step();
    end
    chk("drain_idle", 64'(m_phase == 0 && req == 0 && flush == 0), 64'd1);
  endtask

  task automatic one_sample(input int ch, output logic yv, output int lat);
    logic got;
    yv = 1'b0; lat = 0; got = 1'b0;
    req[ch] = 1'b1;
    x_bus[8*ch +: 8] = 8'($urandom);
    snap();
    for (int n = 1; n <= 12; n++) begin
      step();
      if (gnt[ch]) got = 1'b1;
      if (y_valid) begin yv = 1'b1; lat = n; end
      if (got && m_phase == 0) break;
    end
    chk("sample_complete", 64'(got && m_phase == 0), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] pat;
    logic       yv;
    int         lat, yv_at, ack_at;
    logic [3:0] exp_rr [5];
    reset = 1'b1; req = '0; flush = '0; x_bus = '0; eng_done = 1'b0; eng_y = '0;
    eng_val = 10'h0F0; load_cnt = 0;
    model_reset();
    do_reset();

    // warm-up on channel 0, result 0x0F0 one cycle after load
    pat = '0;
    for (int s = 1; s <= 10; s++) begin
      one_sample(0, yv, lat);
      pat[s-1] = yv;
      if (s == 9) chk("warmup_latency", 64'(lat), 64'd3);
    end
    chk("warmup_yv_pattern", 64'(pat), 64'(10'b11_0000_0000));

    // round robin with all requests held
    do_reset();
    gnt_log.delete(); load_cnt = 0;
    hold_mode = 1'b1; req = 4'b1111; snap();
    for (int n = 0; n < 60 && gnt_log.size() < 5; n++) step();
    chk("rr_grants", 64'(gnt_log.size()), 64'd5);
`ifdef CS_SCHED_PRIO_EN
    exp_rr = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) chk("rr_gnt_seq", 64'(gnt_log[i]), 64'(exp_rr[i]));
    chk("rr_loads", 64'(load_cnt), 64'd5);
    hold_mode = 1'b0; req = '0; snap();
    drain();

`ifdef CS_SCHED_PRIO_EN
    // channel 0 priority while req[0] held, then 1 and 3 round-robin
    do_reset();
    gnt_log.delete();
    hold_mode = 1'b1; req = 4'b1011; snap();
    for (int n = 0; n < 40 && gnt_log.size() < 3; n++) step();
    req[0] = 1'b0; snap();
    for (int n = 0; n < 40 && gnt_log.size() < 5; n++) step();
    chk("prio_grants", 64'(gnt_log.size()), 64'd5);
    exp_rr = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b1000};
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) chk("prio_gnt_seq", 64'(gnt_log[i]), 64'(exp_rr[i]));
    hold_mode = 1'b0; req = '0; snap();
    drain();
`endif

    // flush priority over request, one flush per cycle
    do_reset();
    one_sample(1, yv, lat);
    one_sample(2, yv, lat);
    req = 4'b0001; flush = 4'b0110; snap();
    step();
    chk("fp_ack1", 64'(flush_ack), 64'(4'b0010));
    chk("fp_clr1", 64'(eng_clr), 64'd1);
    step();
    chk("fp_ack2", 64'(flush_ack), 64'(4'b0100));
    chk("fp_clr2", 64'(eng_clr), 64'd1);
    step();
    chk("fp_gnt", 64'(gnt), 64'(4'b0001));
    drain();
    // cleared counts: the 9th sample is the first to produce a result
    for (int c = 1; c <= 2; c++) begin
      pat = '0;
      for (int s = 1; s <= 9; s++) begin
        one_sample(c, yv, lat);
        pat[s-1] = yv;
      end
      chk("fp_cleared_count", 64'(pat), 64'(10'b01_0000_0000));
    end

    // flush of channel 2 while its transaction waits on the engine
    eng_delay = 3;
    req[2] = 1'b1; x_bus[23:16] = 8'($urandom); snap();
    step();
    chk("fif_gnt", 64'(gnt), 64'(4'b0100));
    flush[2] = 1'b1; snap();
    yv_at = -1; ack_at = -1;
    for (int n = 1; n <= 15; n++) begin
      step();
      if (y_valid) yv_at = n;
      if (flush_ack[2]) begin ack_at = n; break; end
    end
    chk("fif_yv_step", 64'(yv_at), 64'd4);
    chk("fif_ack_gap", 64'(ack_at - yv_at), 64'd2);
    eng_delay = 1;
    one_sample(2, yv, lat);
    chk("fif_after_no_yv", 64'(yv), 64'd0);

    // reset during WAIT, engine answers late
    eng_delay = 3;
    req = 4'b0010; snap();
    step();
    step();
    req = '0; snap();
    do_reset();
    yv = 1'b0;
    for (int n = 0; n < 6; n++) begin
      step();
      yv = yv | y_valid;
      chk("rst_busy", 64'(busy), 64'd0);
    end
    chk("rst_no_yv", 64'(yv), 64'd0);
    eng_delay = 1;
    hold_mode = 1'b1; req = 4'b1111; snap();
    for (int n = 0; n < 10; n++) begin
      step();
      if (gnt != 0) break;
    end
    chk("rst_first_gnt", 64'(gnt), 64'(4'b0001));
    hold_mode = 1'b0; req = '0; snap();
    drain();

    // randomized traffic
    eng_delay = 0; eng_fixed = 1'b0; rand_mode = 1'b1;
    repeat (1500) step();
    rand_mode = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
